// File: rtl/prog_host.sv
// Host-side sequencer: preloads processor data memory from a byte stream, strobes Start,
// waits for Ack (with timeout), then streams the result bytes back out.
module prog_host #(
  parameter int LOAD_BASE    = 0,
  parameter int RES_BASE     = 64,
  parameter int RES_LEN      = 8,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4095
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Go,
  input  logic        InValid,
  input  logic [7:0]  InData,
  input  logic        InLast,
  output logic        InReady,
  output logic [7:0]  MemAddr,
  output logic        MemWrEn,
  output logic [7:0]  MemWrData,
  input  logic [7:0]  MemRdData,
  output logic        Start,
  input  logic        Ack,
  output logic        OutValid,
  output logic [7:0]  OutData,
  output logic        OutLast,
  input  logic        OutReady,
  output logic        Busy,
  output logic        Done,
  output logic        TimedOut,
  output logic [15:0] RunCycles
);

  localparam int              SCW         = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCW-1:0]  START_LAST  = SCW'(START_CYCLES - 1);
  localparam logic [7:0]      LOAD_BASE_B = 8'(LOAD_BASE);
  localparam logic [7:0]      RES_BASE_B  = 8'(RES_BASE);
  localparam logic [7:0]      RES_LAST    = 8'(RES_LEN - 1);
  localparam logic [15:0]     TIMEOUT_W   = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, ABORT} state_e;

  state_e         state_q, state_d;
  logic [7:0]     load_idx_q, load_idx_d;
  logic [7:0]     out_idx_q, out_idx_d;
  logic [SCW-1:0] start_cnt_q, start_cnt_d;
  logic [15:0]    run_cycles_q, run_cycles_d;
  logic           timed_out_q, timed_out_d;
  logic           done_q, done_d;
  logic [15:0]    run_inc;
  logic           out_last;

  assign run_inc  = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
  assign out_last = (out_idx_q == RES_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      load_idx_q   <= '0;
      out_idx_q    <= '0;
      start_cnt_q  <= '0;
      run_cycles_q <= '0;
      timed_out_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_idx_q   <= load_idx_d;
      out_idx_q    <= out_idx_d;
      start_cnt_q  <= start_cnt_d;
      run_cycles_q <= run_cycles_d;
      timed_out_q  <= timed_out_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_idx_d   = load_idx_q;
    out_idx_d    = out_idx_q;
    start_cnt_d  = start_cnt_q;
    run_cycles_d = run_cycles_q;
    timed_out_d  = timed_out_q;
    done_d       = 1'b0;
    InReady      = 1'b0;
    MemWrEn      = 1'b0;
    MemWrData    = InData;
    MemAddr      = 8'd0;
    Start        = 1'b0;
    OutValid     = 1'b0;
    OutData      = MemRdData;
    OutLast      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Go) begin
          state_d     = LOAD;
          timed_out_d = 1'b0;
          load_idx_d  = '0;
          out_idx_d   = '0;
        end
      end
      LOAD: begin
        InReady = 1'b1;
        MemWrEn = InValid;
        MemAddr = LOAD_BASE_B + load_idx_q;
        if (InValid) begin
          load_idx_d = load_idx_q + 8'd1;
          if (InLast) begin
            state_d      = START;
            start_cnt_d  = '0;
            run_cycles_d = '0;
          end
        end
      end
      START: begin
        Start       = 1'b1;
        start_cnt_d = start_cnt_q + SCW'(1);
        if (start_cnt_q == START_LAST) state_d = RUN;
      end
      RUN: begin
        // Ack on the timeout edge wins; the abort edge itself does not count a cycle.
        if (Ack) begin
          state_d      = DRAIN;
          run_cycles_d = run_inc;
        end else if (run_cycles_q == TIMEOUT_W) begin
          state_d     = ABORT;
          timed_out_d = 1'b1;
        end else begin
          run_cycles_d = run_inc;
        end
      end
      DRAIN: begin
        MemAddr  = RES_BASE_B + out_idx_q;
        OutValid = 1'b1;
        OutLast  = out_last;
        if (OutReady) begin
          out_idx_d = out_idx_q + 8'd1;
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q | (state_q == ABORT);
  assign TimedOut  = timed_out_q;
  assign RunCycles = run_cycles_q;

endmodule

// File: doc/prog_host.md
PROG_HOST -- requirements
Module: prog_host

Interface
REQ-001 Parameter LOAD_BASE, default 0: data-memory address of the first preload byte.
REQ-002 Parameter RES_BASE, default 64: data-memory address of the first result byte.
REQ-003 Parameter RES_LEN, default 8: number of result bytes returned; legal range 1..255.
REQ-004 Parameter START_CYCLES, default 2: width of the Start pulse in cycles; minimum 1.
REQ-005 Parameter TIMEOUT, default 4095: maximum number of RUN cycles before abort; legal range 1..65534.
REQ-006 Port Clk, input, 1: clock; all state changes on posedge.
REQ-007 Port Reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Port Go, input, 1: request one load/run/drain sequence.
REQ-009 Port InValid, input, 1: preload byte valid.
REQ-010 Port InData, input, 8: preload byte.
REQ-011 Port InLast, input, 1: marks the final preload byte.
REQ-012 Port InReady, output, 1: preload byte accepted.
REQ-013 Port MemAddr, output, 8: data-memory address.
REQ-014 Port MemWrEn, output, 1: data-memory write enable.
REQ-015 Port MemWrData, output, 8: data-memory write data.
REQ-016 Port MemRdData, input, 8: combinational data-memory read data.
REQ-017 Port Start, output, 1: start strobe to the processor.
REQ-018 Port Ack, input, 1: processor done flag.
REQ-019 Port OutValid, output, 1: result byte valid.
REQ-020 Port OutData, output, 8: result byte.
REQ-021 Port OutLast, output, 1: marks the final result byte.
REQ-022 Port OutReady, input, 1: result consumer ready.
REQ-023 Port Busy, output, 1: asserted in every state except IDLE.
REQ-024 Port Done, output, 1: one-cycle pulse at sequence end.
REQ-025 Port TimedOut, output, 1: sticky abort flag.
REQ-026 Port RunCycles, output, 16: processor run-cycle count.

Function
REQ-027 The FSM SHALL have states IDLE, LOAD, START, RUN, DRAIN and ABORT.
REQ-028 In IDLE, Go=1 SHALL move the FSM to LOAD, clear TimedOut, and zero the load index and output index; Go SHALL be ignored in every other state.
REQ-029 In LOAD, InReady SHALL be 1 and MemWrEn SHALL equal InValid; MemAddr SHALL equal LOAD_BASE+LoadIdx, modulo 256; MemWrData SHALL equal InData.
REQ-030 LoadIdx SHALL increment on each accepted byte and wrap from 255 to 0; an accepted byte with InLast=1 SHALL move the FSM to START on the next cycle.
REQ-031 In START, Start SHALL be 1 for exactly START_CYCLES cycles; RunCycles SHALL be cleared on entry, Ack SHALL be ignored, and the FSM SHALL then move to RUN.
REQ-032 In RUN, Start SHALL be 0 and RunCycles SHALL increment once per cycle, saturating at 16'hFFFF.
REQ-033 In RUN, Ack=1 sampled on a clock edge SHALL move the FSM to DRAIN, and RunCycles SHALL hold its value from that point.
REQ-034 In RUN, if RunCycles equals TIMEOUT with Ack=0, the FSM SHALL move to ABORT; Ack=1 on the same edge SHALL take priority and move the FSM to DRAIN.
REQ-035 ABORT SHALL last one cycle, assert Done=1, set TimedOut=1, and return the FSM to IDLE without draining.
REQ-036 In DRAIN, MemAddr SHALL equal RES_BASE+OutIdx, modulo 256; OutValid SHALL be 1, OutData SHALL equal MemRdData, and OutLast SHALL equal (OutIdx==RES_LEN-1).
REQ-037 In DRAIN, OutIdx SHALL advance only when OutValid&&OutReady; OutValid, OutData and OutLast SHALL stay stable while OutReady=0.
REQ-038 The handshake with OutLast=1 SHALL return the FSM to IDLE, and Done SHALL be 1 in the first IDLE cycle.
REQ-039 MemWrEn SHALL be 0 in every state except LOAD; InReady SHALL be 0 outside LOAD; OutValid SHALL be 0 outside DRAIN.
REQ-040 Outside LOAD and DRAIN, MemAddr SHALL be 0.
REQ-041 Done SHALL be high for exactly one cycle per Go-initiated sequence.

Reset
REQ-042 Reset_n=0 SHALL asynchronously force the FSM to IDLE.
REQ-043 Reset_n=0 SHALL force Start, MemWrEn, InReady, OutValid, OutLast, Busy, Done and TimedOut to 0.
REQ-044 Reset_n=0 SHALL zero RunCycles, LoadIdx and OutIdx.
REQ-045 Reset asserted mid-sequence SHALL abort the sequence with no Done pulse and no further memory writes.

Verification
REQ-046 Basic run: Go, then 3 bytes 0x11, 0x22, 0x33 (InLast on the 3rd), then Ack=1 10 cycles after Start falls, with OutReady=1 -> writes at addresses 0, 1 and 2; Start high for 2 cycles; 8 OutValid beats from addresses 64..71; OutLast on the 8th beat; RunCycles=10; one Done pulse.
REQ-047 Backpressure: in DRAIN, toggle OutReady 1, 0, 0, 1 -> OutData held constant across the stall cycles; no byte skipped or duplicated.
REQ-048 Timeout: TIMEOUT=20 with Ack never asserted -> ABORT after RunCycles=20; Done=1 and TimedOut=1; OutValid never asserted.
REQ-049 Ack timing: Ack=1 throughout START -> ignored; the FSM enters DRAIN on the first RUN edge with Ack=1 and RunCycles=1.
REQ-050 Reset mid-LOAD after 2 bytes -> all outputs 0 immediately; a subsequent Go restarts with the write to LOAD_BASE.
REQ-051 Wrap: LOAD_BASE=254 with 4 bytes -> writes to addresses 254, 255, 0 and 1.
